// File: rtl/frame_capture_ram.sv
// Simple dual-port frame capture RAM (one write port, one read-first read port).
// Latency: 1 cycle, or 2 with FRAME_CAPTURE_RAM_OUTREG_EN defined (extra output register).
// Backpressure: none; a read is accepted every cycle and a write whenever wr_en is high.
module frame_capture_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  // Array is never reset so contents survive rst_n; writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking update gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

`ifdef FRAME_CAPTURE_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign rd_data = out_q;
`else
  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_frame_capture_ram.sv
// Directed + randomized bench for frame_capture_ram against an array reference model.
module tb_frame_capture_ram;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;
`ifdef FRAME_CAPTURE_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];

  frame_capture_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
    known[a] = 1'b1;
  endtask

  // Present one read address, then let it drain through the read latency.
  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    wr_en   = 1'b0;
    rd_addr = a;
    tick();
    repeat (LAT - 1) begin
      rd_addr = '0;
      tick();
    end
    chk(tag, rd_data, exp);
  endtask

  initial begin : stim
    int         idx;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    logic          we;
    logic [DW:0]   dq [$];
    logic [DW:0]   ent;

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // Reset state
    #2;
    chk("reset_initial", rd_data, 16'h0000);
    repeat (3) tick();
    chk("reset_held", rd_data, 16'h0000);
    rst_n = 1'b1;

    // Full sweep: write every address, then read them back-to-back
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), 16'(16'hFFFF - a));
    for (int i = 0; i < DEPTH + LAT - 1; i++) begin
      rd_addr = (i < DEPTH) ? AW'(i) : '0;
      tick();
      idx = i - (LAT - 1);
      if (idx >= 0 && idx < DEPTH) chk("sweep", rd_data, model[idx]);
    end

    // Read-during-write returns the old word, new word next read
    wr(11'h010, 16'h1234);
    wr_en   = 1'b1;
    wr_addr = 11'h010;
    wr_data = 16'hABCD;
    rd_addr = 11'h010;
    tick();
    wr_en = 1'b0;
    model[11'h010] = 16'hABCD;
    repeat (LAT - 1) begin
      rd_addr = '0;
      tick();
    end
    chk("rdw_old", rd_data, 16'h1234);
    rd_check("rdw_new", 11'h010, 16'hABCD);

    // Write gating with wr_en low
    wr(11'h7FF, 16'h1111);
    wr_en   = 1'b0;
    wr_addr = 11'h7FF;
    wr_data = 16'h5555;
    tick();
    rd_check("gate_wr_en", 11'h7FF, 16'h1111);

    // Retention + write blocking in reset + async reset between clocks
    wr(11'h400, 16'h00FF);
    rd_addr = 11'h400;
    repeat (LAT) tick();
    chk("pre_reset_rd", rd_data, 16'h00FF);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_async_fall", rd_data, 16'h0000);
    wr_en   = 1'b1;
    wr_addr = 11'h7FF;
    wr_data = 16'h5555;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 5 == 4) chk("reset_hold_200ns", rd_data, 16'h0000);
    end
    wr_en = 1'b0;
    rst_n = 1'b1;
    // First edge after release both writes and reads normally
    wr_en   = 1'b1;
    wr_addr = 11'h005;
    wr_data = 16'h0BEE;
    rd_addr = 11'h400;
    tick();
    wr_en = 1'b0;
    model[11'h005] = 16'h0BEE;
    repeat (LAT - 1) begin
      rd_addr = '0;
      tick();
    end
    chk("retention", rd_data, 16'h00FF);
    rd_check("first_edge_write", 11'h005, 16'h0BEE);
    rd_check("gate_rst_n", 11'h7FF, 16'h1111);

    // Address boundaries
    wr(11'h000, 16'hAAAA);
    wr(11'h7FF, 16'h5555);
    rd_check("bound_lo", 11'h000, 16'hAAAA);
    rd_check("bound_hi", 11'h7FF, 16'h5555);
    rd_check("bound_lo_again", 11'h000, 16'hAAAA);

    // Random traffic in a narrow window so read/write collisions are frequent
    dq.delete();
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(32, 47));
      ra = AW'($urandom_range(32, 47));
      wd = DW'($urandom);
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      rd_addr = ra;
      dq.push_back({known[ra], model[ra]});
      if (we) begin
        model[wa] = wd;
        known[wa] = 1'b1;
      end
      tick();
      if (dq.size() == LAT) begin
        ent = dq.pop_front();
        if (ent[DW]) chk("random", rd_data, ent[DW-1:0]);
      end
    end
    wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_capture_ram.md
FRAME_CAPTURE_RAM -- requirements
Module: frame_capture_ram

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, word-address width (depth 2**ADDR_WIDTH = 2048).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, width of a stored word.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all writes, reads and registers use its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit, write enable.
REQ-006 The block SHALL have port wr_addr, input, ADDR_WIDTH bits, write word address.
REQ-007 The block SHALL have port wr_data, input, DATA_WIDTH bits, write data.
REQ-008 The block SHALL have port rd_addr, input, ADDR_WIDTH bits, read word address; read is always enabled.
REQ-009 The block SHALL have port rd_data, output, DATA_WIDTH bits, read data.

Function
REQ-010 The block SHALL be a simple dual-port RAM of 2**ADDR_WIDTH words x DATA_WIDTH bits, one write port and one read port, both on clk.
REQ-011 With rst_n high and wr_en high at a rising clk edge, the block SHALL store wr_data at wr_addr; with wr_en low, memory SHALL be unchanged.
REQ-012 Every rising clk edge with rst_n high, the block SHALL sample rd_addr; the addressed word SHALL appear on rd_data after that edge (latency 1 cycle) and hold until the next edge.
REQ-013 The block SHALL be read-first: a read and a write to the same address in the same cycle SHALL return the old contents; the new word SHALL be readable from the following cycle.
REQ-014 Addresses SHALL cover the full range 0..2**ADDR_WIDTH-1 with no wrap or aliasing; no out-of-range condition exists.
REQ-015 Memory contents SHALL be undefined after power-up; no initialisation file is supported.
REQ-016 The block SHALL have no byte enables, clock enables, address strobes or output clock enable.

Reset
REQ-017 While rst_n is low, the block SHALL asynchronously force rd_data (and any output pipeline register) to all zeros.
REQ-018 While rst_n is low, the block SHALL ignore wr_en; no write SHALL occur.
REQ-019 Reset SHALL NOT clear memory contents; words written before reset SHALL be readable after reset release.
REQ-020 After rst_n rises, the first rising clk edge SHALL perform a normal read/write per REQ-011..REQ-013.
REQ-021 Reset asserted mid-burst SHALL abort only the cycles during which rst_n is low; previously completed writes SHALL persist.

Configuration
REQ-022 With macro FRAME_CAPTURE_RAM_OUTREG_EN defined, the block SHALL add one output register after the RAM read stage, making read latency 2 cycles, the register reset to zero per REQ-017.
REQ-023 Without FRAME_CAPTURE_RAM_OUTREG_EN, read latency SHALL be 1 cycle per REQ-012; all other behaviour SHALL be identical in both builds.

Verification
REQ-024 Full sweep: write addr a = 0..2047 with data 0xFFFF-a, then read addr 0..2047 consecutively -> rd_data one cycle after each read address (two with OUTREG_EN) equals 0xFFFF-a; zero mismatches.
REQ-025 Reset value: hold rst_n low for 200 ns, then check -> rd_data = 0x0000 throughout reset, including immediately on the falling edge of rst_n between clocks.
REQ-026 Read-during-write: addr 0x010 holds 0x1234; same cycle write 0xABCD and read 0x010 -> rd_data 0x1234 next cycle; reading 0x010 again -> 0xABCD.
REQ-027 Write gating: wr_en low with wr_addr 0x7FF and wr_data 0x5555 -> later read of 0x7FF returns the prior contents; the same with rst_n low also produces no write.
REQ-028 Retention: write 0x00FF to addr 0x400, pulse rst_n low, release -> read of 0x400 returns 0x00FF.
REQ-029 Boundary: write 0xAAAA to addr 0x000 and 0x5555 to 0x7FF -> reads return exactly those values with no aliasing between the two addresses.
